// File: rtl/risc8_io_pkg.sv
// Shared definitions for the risc8 IO block:
// register map, UART status bits and timer prescale encodings.
package risc8_io_pkg;

    localparam logic [6:0] A_BAUD  = 7'h2D;
    localparam logic [6:0] A_USTAT = 7'h2E;
    localparam logic [6:0] A_UDATA = 7'h2F;
    localparam logic [6:0] A_PIN0  = 7'h36;
    localparam logic [6:0] A_DDR0  = 7'h37;
    localparam logic [6:0] A_PORT0 = 7'h38;
    localparam logic [6:0] A_TCCR  = 7'h4E;
    localparam logic [6:0] A_TCNT  = 7'h4F;
    localparam logic [6:0] A_TIFR  = 7'h58;
    localparam logic [6:0] A_TIMSK = 7'h59;

    localparam int ST_READY = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVR   = 3;

    localparam logic [7:0] TCCR_RST = 8'h01;
    localparam logic [7:0] BAUD_RST = 8'h05;

    typedef enum logic [2:0] {
        CS_STOP    = 3'd0,
        CS_DIV1    = 3'd1,
        CS_DIV8    = 3'd2,
        CS_DIV64   = 3'd3,
        CS_DIV256  = 3'd4,
        CS_DIV1024 = 3'd5
    } cs_e;

    // Each GPIO port sits three addresses below the previous one
    function automatic logic [6:0] port_addr(logic [6:0] base, int k);
        return base - 7'(3 * k);
    endfunction

    // {running, divisor-1}
    function automatic logic [10:0] ps_top(logic [2:0] cs);
        case (cs_e'(cs))
            CS_DIV1:    return {1'b1, 10'd0};
            CS_DIV8:    return {1'b1, 10'd7};
            CS_DIV64:   return {1'b1, 10'd63};
            CS_DIV256:  return {1'b1, 10'd255};
            CS_DIV1024: return {1'b1, 10'd1023};
            default:    return 11'd0;
        endcase
    endfunction

endpackage

// File: rtl/risc8_io_if.sv
// Core-side data bus into the IO block.
interface risc8_io_if;

    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [7:0]  wdata;
    logic        io_sel;
    logic [7:0]  io_data;

    modport master (
        output addr, wen, ren, wdata,
        input  io_sel, io_data
    );

    modport slave (
        input  addr, wen, ren, wdata,
        output io_sel, io_data
    );

endinterface

// File: rtl/risc8_fifo.sv
// Synchronous FIFO used as the UART transmit queue.
module risc8_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A full queue still accepts a byte when one leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

endmodule

// File: rtl/risc8_io.sv
// risc8 IO block: GPIO ports, UART transmit queue
// and an 8-bit prescaled timer with overflow interrupt.
module risc8_io
    import risc8_io_pkg::*;
#(
    parameter int          NPORTS       = 2,
    parameter int          TXFIFO_DEPTH = 8,
    parameter logic [15:0] IO_LIMIT     = 16'h0060
) (
    input  logic                clk,
    input  logic                reset,
    risc8_io_if.slave           bus,
    input  logic [8*NPORTS-1:0] pin,
    output logic [8*NPORTS-1:0] port,
    output logic [8*NPORTS-1:0] ddr,
    output logic                uart_tx_strobe,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_tx_ready,
    output logic [7:0]          uart_baud_div,
    output logic                timer_irq
);

    localparam int CW = $clog2(TXFIFO_DEPTH) + 1;

    logic [6:0] io_addr;
    logic       is_io;
    logic       wr;
    logic       rd_en;
    logic [7:0] rd_data;

    assign io_addr = bus.addr[6:0];
    assign is_io   = (bus.wen | bus.ren) && (bus.addr < IO_LIMIT);
    assign wr      = is_io && bus.wen;
    assign rd_en   = is_io && bus.ren;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          drop;
    logic          overrun;
    logic [7:0]    status;

    assign push = wr && io_addr == A_UDATA;
    // The strobe term keeps consecutive strobes two cycles apart
    assign pop  = fifo_count != '0 && uart_tx_ready && !uart_tx_strobe;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        status           = '0;
        status[ST_READY] = uart_tx_ready;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVR]   = overrun;
    end

    risc8_fifo #(
        .WIDTH(8),
        .DEPTH(TXFIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(bus.wdata),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    logic [7:0]  tccr;
    logic [7:0]  tcnt;
    logic [7:0]  timsk;
    logic        tifr;
    logic [9:0]  presc;
    logic [10:0] ps;
    logic        tick;
    logic        ovf;
    logic        tccr_wr;
    logic        tcnt_wr;
    logic        tifr_wr;

    assign tccr_wr = wr && io_addr == A_TCCR;
    assign tcnt_wr = wr && io_addr == A_TCNT;
    assign tifr_wr = wr && io_addr == A_TIFR;
    assign ps      = ps_top(tccr[2:0]);
    assign tick    = ps[10] && presc == ps[9:0];
    assign ovf     = tick && tcnt == 8'hFF && !tcnt_wr;

    always_comb begin
        rd_data = {1'b0, io_addr};
        case (io_addr)
            A_BAUD:  rd_data = uart_baud_div;
            A_USTAT: rd_data = status;
            A_TCCR:  rd_data = tccr;
            A_TCNT:  rd_data = tcnt;
            A_TIFR:  rd_data = {7'b0, tifr};
            A_TIMSK: rd_data = timsk;
            default: rd_data = {1'b0, io_addr};
        endcase
        for (int k = 0; k < NPORTS; k++) begin
            if (io_addr == port_addr(A_PIN0, k))  rd_data = pin[8*k +: 8];
            if (io_addr == port_addr(A_DDR0, k))  rd_data = ddr[8*k +: 8];
            if (io_addr == port_addr(A_PORT0, k)) rd_data = port[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.io_sel     <= 1'b0;
            bus.io_data    <= '0;
            port           <= '0;
            ddr            <= '0;
            uart_baud_div  <= BAUD_RST;
            uart_tx_strobe <= 1'b0;
            uart_tx_data   <= '0;
            overrun        <= 1'b0;
            tccr           <= TCCR_RST;
            tcnt           <= '0;
            timsk          <= '0;
            tifr           <= 1'b0;
            presc          <= '0;
            timer_irq      <= 1'b0;
        end else begin
            bus.io_sel <= is_io;
            if (rd_en) bus.io_data <= rd_data;
            if (wr && io_addr == A_BAUD) uart_baud_div <= bus.wdata;
            if (drop) overrun <= 1'b1;
            else if (rd_en && io_addr == A_USTAT) overrun <= 1'b0;
            uart_tx_strobe <= pop;
            if (pop) uart_tx_data <= head;
            if (tccr_wr) tccr <= bus.wdata;
            if (tccr_wr || tick || !ps[10]) presc <= '0;
            else presc <= presc + 10'd1;
            if (tcnt_wr) tcnt <= bus.wdata;
            else if (tick) tcnt <= tcnt + 8'd1;
            // Overflow beats a software clear in the same cycle
            if (ovf) tifr <= 1'b1;
            else if (tifr_wr && bus.wdata[0]) tifr <= 1'b0;
            if (wr && io_addr == A_TIMSK) timsk <= bus.wdata;
            timer_irq <= tifr & timsk[0];
            for (int k = 0; k < NPORTS; k++) begin
                if (wr && io_addr == port_addr(A_DDR0, k))
                    ddr[8*k +: 8] <= bus.wdata;
                if (wr && io_addr == port_addr(A_PORT0, k))
                    port[8*k +: 8] <= bus.wdata;
            end
        end
    end

endmodule

// File: doc/risc8_io.md
RISC8_IO -- requirements
Module: risc8_io

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of GPIO ports, legal range 1..3.
REQ-002 SHALL have parameter TXFIFO_DEPTH, default 8, UART TX FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter IO_LIMIT, default 16'h0060, first address that is not IO.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-006 addr  in  16  data address from core; io_addr = addr[6:0].
REQ-007 wen / ren  in  1 each  data write / read strobe.
REQ-008 wdata  in  8  write data.
REQ-009 io_sel  out  1  registered; high one cycle after an IO access.
REQ-010 io_data  out  8  registered read data.
REQ-011 pin  in  8*NPORTS  GPIO inputs, port k at bits [8k+7:8k].
REQ-012 port / ddr  out  8*NPORTS each  GPIO output and direction registers.
REQ-013 uart_tx_strobe  out  1; uart_tx_data  out  8; uart_tx_ready  in  1; uart_baud_div  out  8.
REQ-014 timer_irq  out  1  timer overflow interrupt request.

Function
REQ-015 An access is IO when (wen|ren) and addr < IO_LIMIT; io_sel SHALL be 1 in the following cycle and 0 otherwise.
REQ-016 Reads SHALL have one-cycle latency; io_data SHALL hold its value when no IO read occurs.
REQ-017 Map: 0x2D baud R/W; 0x2E UART status R; 0x2F UART data W; port k: PIN 0x36-3k R, DDR 0x37-3k R/W, PORT 0x38-3k R/W; 0x4E TCCR R/W; 0x4F TCNT R/W; 0x58 TIFR; 0x59 TIMSK R/W.
REQ-018 Reads of unmapped IO addresses, and of ports k >= NPORTS, SHALL return {1'b0, io_addr}; writes to them SHALL be ignored.
REQ-019 Status SHALL read {4'b0, overrun, full, empty, uart_tx_ready}; overrun SHALL clear on a status read unless it is set in the same cycle.
REQ-020 A write to 0x2F SHALL push wdata when the FIFO is not full or a pop occurs in the same cycle; otherwise data is dropped and overrun is set.
REQ-021 Pop condition: FIFO not empty, uart_tx_ready=1, uart_tx_strobe=0 in the current cycle; pop drives uart_tx_strobe=1 for exactly one cycle with uart_tx_data=head.
REQ-022 A byte pushed into an empty FIFO SHALL NOT pop before the next cycle; consecutive strobes SHALL be at least 2 cycles apart.
REQ-023 FIFO pointers SHALL wrap modulo TXFIFO_DEPTH; full = count==TXFIFO_DEPTH; empty = count==0.
REQ-024 TCCR[2:0] prescale: 0 stop, 1 /1, 2 /8, 3 /64, 4 /256, 5 /1024, 6-7 stop; a 10-bit prescaler SHALL generate a tick when it reaches divisor-1, then return to 0.
REQ-025 A TCCR write SHALL clear the prescaler.
REQ-026 TCNT SHALL increment on each tick; 0xFF->0x00 SHALL set TIFR[0].
REQ-027 A TCNT write SHALL take priority over an increment in the same cycle and SHALL NOT set TIFR[0].
REQ-028 Writing 1 to TIFR[0] SHALL clear it; a simultaneous overflow SHALL win (flag stays 1).
REQ-029 timer_irq SHALL be the registered value of TIFR[0] & TIMSK[0].

Reset
REQ-030 While reset=0: port, ddr, TCNT, TIFR, TIMSK, io_sel, io_data, uart_tx_strobe, overrun, timer_irq = 0; FIFO empty; prescaler 0; TCCR = 0x01; baud = 0x05.
REQ-031 Reset mid-transmit SHALL discard FIFO contents; no strobe SHALL be issued in the first cycle after deassertion.

Structure
REQ-032 Register addresses, status bit positions and prescale encodings SHALL be defined in a shared package, risc8_io_pkg.
REQ-033 The TX FIFO SHALL be one sub-module, risc8_fifo (params WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-034 Reset, then read 0x2D, 0x4E, 0x2E with uart_tx_ready=1 -> 0x05, 0x01, 0x03.
REQ-035 uart_tx_ready=0; write 0x41..0x48 to 0x2F, then 0x49 -> status 0x0C (full, overrun); raise ready -> strobes 0x41..0x48 in order, >=2 cycles apart; status read clears overrun.
REQ-036 NPORTS=2: write 0x34=0xF0, 0x35=0xA5; pin=16'h3C00 -> ddr[15:8]=0xF0, port[15:8]=0xA5, read 0x33 -> 0x3C; read 0x30 -> 0x30.
REQ-037 TCCR=2, TCNT=0xFE, TIMSK=1 -> overflow after 16 clk, TIFR=1, timer_irq=1 next cycle; write TIFR=1 -> irq drops.
REQ-038 Write TCNT=0x10 in the same cycle as a tick -> TCNT reads 0x10; TIFR clear coincident with overflow -> flag stays 1.
